// File: rtl/wb_lsu_master.sv
// Load/store unit turning one core memory request into a single Wishbone classic cycle.
// Optional ack-wait abort is enabled by defining WB_LSU_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module wb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_lsu_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_err;
    logic        r_cyc;
    logic        r_stb;
    logic [31:0] r_adr;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_bus_end;
    logic [3:0]  w_sel;
    logic [31:0] w_wdat;
    logic [31:0] w_shifted;
    logic [31:0] w_rdata;

    assign w_accept  = (r_state == ST_IDLE) && req_i;
    assign w_bus_end = (r_state == ST_BUS) && (wb_ack_i || wb_err_i || w_timeout);

    // Illegal size is folded into the misalignment flag so both skip the bus.
    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = 4'b1111;
        w_wdat       = wdata_i;
        unique case (size_i)
            2'b00: begin
                w_sel  = 4'b0001 << addr_i[1:0];
                w_wdat = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = addr_i[0];
                w_sel        = 4'b0011 << addr_i[1:0];
                w_wdat       = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                w_misaligned = |addr_i[1:0];
            end
            default: begin
                w_misaligned = 1'b1;
            end
        endcase
    end

    assign w_shifted = wb_dat_i >> {r_offset, 3'b000};

    always_comb begin
        w_rdata = w_shifted;
        unique case (r_size)
            2'b00:   w_rdata = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_rdata = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_rdata = w_shifted;
        endcase
    end

`ifdef WB_LSU_TIMEOUT_EN
    logic [15:0] r_wait;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wait <= '0;
        end else if (r_state != ST_BUS) begin
            r_wait <= '0;
        end else if (!wb_ack_i && !wb_err_i) begin
            r_wait <= r_wait + 16'd1;
        end
    end

    // An ack or err on the expiry edge takes precedence over the abort.
    assign w_timeout = (r_state == ST_BUS) && !wb_ack_i && !wb_err_i &&
                       (r_wait == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    w_next = w_misaligned ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (w_bus_end) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bus outputs stay frozen for the whole BUS phase; only cyc/stb drop at its end.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_offset   <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_offset   <= addr_i[1:0];
                r_size     <= size_i;
                r_unsigned <= unsigned_i;
                r_err      <= w_misaligned;
                if (!w_misaligned) begin
                    r_cyc <= 1'b1;
                    r_stb <= 1'b1;
                    r_adr <= {addr_i[31:2], 2'b00};
                    r_we  <= we_i;
                    r_sel <= w_sel;
                    r_dat <= w_wdat;
                end
            end
            if (w_bus_end) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
                if (wb_err_i || w_timeout) begin
                    r_err <= 1'b1;
                end else if (!r_we) begin
                    r_rdata <= w_rdata;
                end
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        err_o  = 1'b0;
        unique case (r_state)
            ST_BUS: begin
                busy_o = 1'b1;
            end
            ST_RESP: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                err_o  = r_err;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign rdata_o  = r_rdata;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_adr_o = r_adr;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_dat_o = r_dat;

endmodule
